mmio_scan_bank: RTL and testbench

- Parametrised successor to the scan-loadable memory bank: a register-file memory plus memory-mapped IO (N output ports, one synchronised input port with sticky rising-edge flags), and a locking-key register.
- All architectural state, except the input synchronisers, sits on one scan chain.
- Sits between the CPU core's address/data bus and the chip pins.
- The key is loaded only via scan.

---
 rtl/mmio_scan_bank.sv | 139 +++++++++++++
 tb/tb_mmio_scan_bank.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_scan_bank.sv
// Register-file RAM + memory-mapped output ports, synchronised input port with sticky rise flags, scan-loaded key.
// Latency: combinational reads; writes, flag capture and scan shifts land on the rising clk edge (irq one edge after its flag).
// Backpressure: none; every access completes in one cycle. Optional EDGE_IRQ_EN adds the IRQ mask register and irq output.
module mmio_scan_bank #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_SIZE   = 14,
    parameter int N_OUT      = 1,
    parameter int IN_WIDTH   = 8,
    parameter int KEY_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [ADDR_WIDTH-1:0]       address,
    input  logic [DATA_WIDTH-1:0]       data_in,
    input  logic                        write_enable,
    output logic [DATA_WIDTH-1:0]       data_out,
    input  logic                        scan_enable,
    input  logic                        scan_in,
    output logic                        scan_out,
    input  logic [IN_WIDTH-1:0]         in_pins,
    output logic [N_OUT*DATA_WIDTH-1:0] out_pins,
    output logic [KEY_WIDTH-1:0]        locking_key
`ifdef EDGE_IRQ_EN
    ,
    output logic                        irq
`endif
);

    // RAM words and output ports are contiguous both in the address map and in the chain,
    // so one word index covers both.
    localparam int unsigned RW_WORDS  = MEM_SIZE + N_OUT;
    localparam int unsigned IN_ADDR   = RW_WORDS;
    localparam int unsigned EDGE_ADDR = IN_ADDR + 1;
`ifdef EDGE_IRQ_EN
    localparam int unsigned MASK_ADDR = IN_ADDR + 2;
    localparam int          MASK_W    = IN_WIDTH;
`else
    localparam int          MASK_W    = 0;
`endif
    localparam int FLG_OFF   = RW_WORDS * DATA_WIDTH;
    localparam int MASK_OFF  = FLG_OFF + IN_WIDTH;
    localparam int KEY_OFF   = MASK_OFF + MASK_W;
    localparam int CHAIN_LEN = KEY_OFF + KEY_WIDTH;

    // All scannable state lives in one flat vector; bit 0 is the chain head (mem[0] LSB).
    logic [CHAIN_LEN-1:0] chain_q, chain_d;
    logic [IN_WIDTH-1:0]  s1_q, s2_q, s3_q;
    logic [IN_WIDTH-1:0]  flags, rise, clr;
    logic [31:0]          addr_w, word_idx;

    assign addr_w   = 32'(address);
    assign word_idx = addr_w * 32'(DATA_WIDTH);
    assign flags    = chain_q[FLG_OFF +: IN_WIDTH];
    assign rise     = s2_q & ~s3_q;

    assign out_pins    = chain_q[MEM_SIZE*DATA_WIDTH +: N_OUT*DATA_WIDTH];
    assign locking_key = chain_q[KEY_OFF +: KEY_WIDTH];
    assign scan_out    = chain_q[CHAIN_LEN-1];

    // Next state: shift the whole chain in scan mode, otherwise apply bus writes and flag capture.
    always_comb begin
        chain_d = chain_q;
        clr     = '0;
        if (scan_enable) begin
            chain_d = {chain_q[CHAIN_LEN-2:0], scan_in};
        end else begin
            if (write_enable) begin
                if (addr_w < RW_WORDS) begin
                    chain_d[word_idx +: DATA_WIDTH] = data_in;
                end
                if (addr_w == EDGE_ADDR) begin
                    clr = data_in[IN_WIDTH-1:0];
                end
`ifdef EDGE_IRQ_EN
                if (addr_w == MASK_ADDR) begin
                    chain_d[MASK_OFF +: IN_WIDTH] = data_in[IN_WIDTH-1:0];
                end
`endif
            end
            // A rise arriving together with its clear keeps the flag set.
            chain_d[FLG_OFF +: IN_WIDTH] = (flags & ~clr) | rise;
        end
    end

    // Chain state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    // Three-stage pin synchroniser; runs in scan mode too and stays off the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= in_pins;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

`ifdef EDGE_IRQ_EN
    logic irq_q;

    // Registered interrupt: follows the masked flags one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(flags & chain_q[MASK_OFF +: IN_WIDTH]);
        end
    end

    assign irq = irq_q;
`endif

    // Read mux: pure function of address and current state; unmapped addresses read as 1.
    always_comb begin
        data_out = DATA_WIDTH'(1);
        if (addr_w < RW_WORDS) begin
            data_out = chain_q[word_idx +: DATA_WIDTH];
        end else if (addr_w == IN_ADDR) begin
            data_out = DATA_WIDTH'(s2_q);
        end else if (addr_w == EDGE_ADDR) begin
            data_out = DATA_WIDTH'(flags);
`ifdef EDGE_IRQ_EN
        end else if (addr_w == MASK_ADDR) begin
            data_out = DATA_WIDTH'(chain_q[MASK_OFF +: IN_WIDTH]);
`endif
        end
    end

endmodule

// File: tb/tb_mmio_scan_bank.sv
module tb_mmio_scan_bank;
    localparam int AW = 5, DW = 8, MS = 14, NO = 1, IW = 8, KW = 16;
    localparam int NW = MS + NO;
`ifdef EDGE_IRQ_EN
    localparam int MW = IW;
`else
    localparam int MW = 0;
`endif
    localparam int L = NW*DW + IW + MW + KW;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [AW-1:0]  address = '0;
    logic [DW-1:0]  data_in = '0;
    logic           write_enable = 1'b0;
    logic [DW-1:0]  data_out;
    logic           scan_enable = 1'b0;
    logic           scan_in = 1'b0;
    logic           scan_out;
    logic [IW-1:0]  in_pins = '0;
    logic [NO*DW-1:0] out_pins;
    logic [KW-1:0]  locking_key;
`ifdef EDGE_IRQ_EN
    logic           irq;
`endif

    mmio_scan_bank dut (
        .clk(clk), .rst_n(rst_n), .address(address), .data_in(data_in),
        .write_enable(write_enable), .data_out(data_out),
        .scan_enable(scan_enable), .scan_in(scan_in), .scan_out(scan_out),
        .in_pins(in_pins), .out_pins(out_pins), .locking_key(locking_key)
`ifdef EDGE_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: architectural words plus pin history (p1 = pin at last edge, p2 two edges ago ...)
    logic [DW-1:0] m_words [NW];
    logic [IW-1:0] m_flags, m_mask, p1, p2, p3;
    logic [KW-1:0] m_key;
    logic          m_irq;
    bit            chain_m[$];
    int            n_cmp = 0, n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < NW; w++) m_words[w] = '0;
        m_flags = '0; m_mask = '0; m_key = '0; m_irq = 1'b0;
        p1 = '0; p2 = '0; p3 = '0;
    endtask

    // Serialise the model into scan order: element 0 is nearest scan_in, last element drives scan_out.
    task automatic pack();
        chain_m.delete();
        for (int w = 0; w < NW; w++) for (int b = 0; b < DW; b++) chain_m.push_back(m_words[w][b]);
        for (int b = 0; b < IW; b++) chain_m.push_back(m_flags[b]);
`ifdef EDGE_IRQ_EN
        for (int b = 0; b < IW; b++) chain_m.push_back(m_mask[b]);
`endif
        for (int b = 0; b < KW; b++) chain_m.push_back(m_key[b]);
    endtask

    task automatic unpack();
        int k = 0;
        for (int w = 0; w < NW; w++) for (int b = 0; b < DW; b++) m_words[w][b] = chain_m[k++];
        for (int b = 0; b < IW; b++) m_flags[b] = chain_m[k++];
`ifdef EDGE_IRQ_EN
        for (int b = 0; b < IW; b++) m_mask[b] = chain_m[k++];
`endif
        for (int b = 0; b < KW; b++) m_key[b] = chain_m[k++];
    endtask

    function automatic logic [DW-1:0] model_read(input int a);
        if (a < NW) return m_words[a];
        if (a == NW) return DW'(p2);
        if (a == NW + 1) return DW'(m_flags);
`ifdef EDGE_IRQ_EN
        if (a == NW + 2) return DW'(m_mask);
`endif
        return DW'(1);
    endfunction

    // Advance the model by one clock edge using the inputs currently driven, then let the DUT take that edge.
    task automatic tick();
        logic [IW-1:0] rise, clr, old_f, old_m;
        rise = p2 & ~p3; old_f = m_flags; old_m = m_mask; clr = '0;
        if (scan_enable) begin
            pack();
            void'(chain_m.pop_back());
            chain_m.push_front(scan_in);
            unpack();
        end else begin
            if (write_enable) begin
                if (int'(address) < NW) m_words[address] = data_in;
                else if (int'(address) == NW + 1) clr = data_in[IW-1:0];
`ifdef EDGE_IRQ_EN
                else if (int'(address) == NW + 2) m_mask = data_in[IW-1:0];
`endif
            end
            m_flags = (m_flags & ~clr) | rise;
        end
        m_irq = |(old_f & old_m);
        p3 = p2; p2 = p1; p1 = in_pins;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        address = AW'(a); data_in = d; write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input int a, input logic [DW-1:0] exp);
        address = AW'(a);
        #1;
        check_val(tag, 32'(data_out), 32'(exp));
        check_val({tag, "_model"}, 32'(data_out), 32'(model_read(a)));
    endtask

    task automatic chk_outs(input string tag);
        check_val({tag, "_out_pins"}, 32'(out_pins), 32'(m_words[NW-1]));
        check_val({tag, "_key"}, 32'(locking_key), 32'(m_key));
        check_val({tag, "_scan_out"}, 32'(scan_out), 32'(m_key[KW-1]));
`ifdef EDGE_IRQ_EN
        check_val({tag, "_irq"}, 32'(irq), 32'(m_irq));
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit            snap[$];
        logic [L-1:0]  pat;
        logic [7:0]    lastb;
        model_reset();

        // Reset state: scan_in high with scan_enable must not leak to scan_out.
        scan_in = 1'b1; scan_enable = 1'b1;
        @(negedge clk); @(negedge clk);
        check_val("rst_scan_out", 32'(scan_out), 32'd0);
        check_val("rst_out_pins", 32'(out_pins), 32'd0);
        check_val("rst_key", 32'(locking_key), 32'd0);
        for (int a = 0; a < 32; a++) begin
            address = AW'(a);
            #1;
            check_val($sformatf("rst_rd%0d", a), 32'(data_out), (a < NW + 2 + (MW > 0 ? 1 : 0)) ? 32'd0 : 32'd1);
        end
        scan_enable = 1'b0; scan_in = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Functional writes and read-only IN port.
        wr(3, 8'hA5);
        wr(14, 8'h3C);
        rd_chk("ram3", 3, 8'hA5);
        check_val("out_pins_3c", 32'(out_pins), 32'h3C);
        wr(15, 8'hFF);
        rd_chk("in_ro", 15, 8'h00);
        rd_chk("ram3_keep", 3, 8'hA5);

        // Pin sync and sticky flags.
        in_pins = 8'h81;
        tick(); rd_chk("in_e1", 15, 8'h00);
        tick(); rd_chk("in_e2", 15, 8'h81); rd_chk("edge_e2", 16, 8'h00);
        tick(); rd_chk("edge_e3", 16, 8'h81);
        wr(16, 8'h01);
        rd_chk("edge_w1c", 16, 8'h80);

        // Rise on pin0 coinciding with a W1C of bit0: set wins.
        in_pins = 8'h00;
        tick(); tick(); tick();
        in_pins = 8'h01;
        tick(); tick();
        wr(16, 8'h01);
        rd_chk("edge_set_wins", 16, 8'h81);

`ifdef EDGE_IRQ_EN
        wr(16, 8'hFF);
        wr(17, 8'h02);
        rd_chk("mask_rd", 17, 8'h02);
        in_pins = 8'h02;
        tick(); tick(); tick();
        check_val("irq_pre", 32'(irq), 32'd0);
        tick();
        check_val("irq_set", 32'(irq), 32'd1);
        wr(16, 8'h02);
        chk_outs("irq_w1c");
        tick();
        check_val("irq_clr", 32'(irq), 32'd0);
`endif

        // Randomised traffic mixing writes, reads, pin activity and short scan bursts.
        for (int c = 0; c < 400; c++) begin
            address = AW'($urandom_range(0, 31));
            data_in = DW'($urandom);
            write_enable = ($urandom_range(0, 2) != 0);
            scan_enable = ($urandom_range(0, 5) == 0);
            scan_in = 1'($urandom);
            if ($urandom_range(0, 3) == 0) in_pins = IW'($urandom);
            #1;
            check_val("rand_rd", 32'(data_out), 32'(model_read(int'(address))));
            chk_outs("rand");
            tick();
        end
        write_enable = 1'b0; scan_enable = 1'b0;
        in_pins = 8'h00;

        // Full-length scan load: key BEEF shifted first, byte 5A shifted last lands in mem[0].
        pat = {L{1'b0}};
        for (int i = 0; i < L; i++) pat[i] = 1'($urandom);
        for (int i = 0; i < KW; i++) pat[i] = 1'((16'hBEEF >> (KW - 1 - i)) & 1);
        lastb = 8'h5A;
        for (int j = 0; j < 8; j++) pat[L - 1 - j] = lastb[j];
        pack();
        snap = chain_m;
        scan_enable = 1'b1;
        for (int i = 0; i < L; i++) begin
            scan_in = pat[i];
            write_enable = (i == 20);
            address = 5'd3; data_in = 8'h00;
            #1;
            check_val("scan_replay", 32'(scan_out), 32'(snap[L - 1 - i]));
            tick();
        end
        scan_enable = 1'b0; write_enable = 1'b0;
        check_val("scan_key", 32'(locking_key), 32'hBEEF);
        rd_chk("scan_mem0", 0, 8'h5A);
        chk_outs("post_scan");
        for (int a = 0; a < NW + 2; a++) begin
            address = AW'(a);
            #1;
            check_val("post_scan_rd", 32'(data_out), 32'(model_read(a)));
        end

        // Asynchronous reset in the middle of a scan.
        scan_enable = 1'b1; scan_in = 1'b1;
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_val("mid_rst_key", 32'(locking_key), 32'd0);
        check_val("mid_rst_out", 32'(out_pins), 32'd0);
        check_val("mid_rst_scan_out", 32'(scan_out), 32'd0);
        address = 5'd0;
        #1;
        check_val("mid_rst_mem0", 32'(data_out), 32'd0);
`ifdef EDGE_IRQ_EN
        check_val("mid_rst_irq", 32'(irq), 32'd0);
`endif
        @(negedge clk);
        scan_enable = 1'b0; scan_in = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        rd_chk("after_rst_ram3", 3, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
